ic_enq_arbiter: RTL and testbench
=================================

IC_ENQ_ARBITER -- requirements
Module: ic_enq_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORE, default 4, number of producer cores sharing one queue.
REQ-002 SHALL have parameter DEPTH, default 32, number of entries in the downstream queue.
REQ-003 SHALL have port clk  input  1  clock; reset rst_n, asynchronous, active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NUM_CORE  per-core enqueue request; each core holds its request and data stable until its ack.
REQ-006 SHALL have port deq_req  input  1  consumer dequeue request.
REQ-007 SHALL have port q_en  output  1  registered enqueue strobe to the queue.
REQ-008 SHALL have port core_id  output  NUM_CORE  registered one-hot source select, valid while q_en=1.
REQ-009 SHALL have port ack  output  NUM_CORE  one-hot; equals core_id gated by q_en.
REQ-010 SHALL have port deq_gnt  output  1  combinational accepted dequeue: deq_req AND NOT empty.
REQ-011 SHALL have port count  output  $clog2(DEPTH+1)  committed queue occupancy.
REQ-012 SHALL have ports full and empty  output  1 each  count==DEPTH and count==0.

Function
REQ-013 SHALL arbitrate round-robin: the eligible core with the lowest index strictly above the last granted index wins, wrapping to 0.
REQ-014 SHALL treat core i as eligible when req[i]=1 and ack[i]=0 in the current cycle.
REQ-015 SHALL grant only when (count + q_en) < DEPTH; otherwise no grant is made and the pointer holds.
REQ-016 SHALL, on a grant in cycle t, drive q_en=1 and core_id/ack one-hot for the winner in cycle t+1 (one-cycle latency).
REQ-017 SHALL hold q_en high for exactly one cycle per grant; back-to-back grants to different cores SHALL sustain one enqueue per cycle.
REQ-018 SHALL update the last-granted pointer only on a grant.
REQ-019 SHALL increment count on the clock edge ending a cycle with q_en=1 and deq_gnt=0.
REQ-020 SHALL decrement count on the clock edge ending a cycle with deq_gnt=1 and q_en=0.
REQ-021 SHALL leave count unchanged when q_en=1 and deq_gnt=1 in the same cycle.
REQ-022 SHALL drive deq_gnt=0 whenever count==0, even if q_en=1 that cycle, since the entry is not yet written.
REQ-023 SHALL never let count exceed DEPTH or go below 0.
REQ-024 SHALL keep core_id at all-zero whenever q_en=0.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear q_en, core_id, and ack; set count=0, empty=1, and full=0; and set the pointer to NUM_CORE-1 so core 0 wins first.
REQ-026 SHALL, on reset mid-transfer, drop any pending grant without emitting q_en after reset release.
REQ-027 SHALL make its first possible grant in the first cycle after rst_n deasserts; the resulting q_en appears in the cycle after that.

Structure
REQ-028 SHALL take NUM_CORE, DEPTH, and the count width from the shared package rt_ic_pkg, which also holds the RT-to-IC and IC-to-RT payload widths.
REQ-029 SHALL instantiate one sub-module rr_arbiter (request vector, pointer in, one-hot grant out, combinational).
REQ-030 SHALL keep occupancy tracking and output registers in the top module.

Verification
REQ-031 Verification SHALL cover the following scenario: after reset, req=4'b1111 held -> q_en=1 on four consecutive cycles with core_id 0001, 0010, 0100, 1000, then the pattern repeats starting at 0001.
REQ-032 Verification SHALL cover the following scenario: req=4'b0100 only, each core deasserting req the cycle after its ack -> one grant, ack[2] for one cycle, count goes 0->1, no second q_en.
REQ-033 Verification SHALL cover the following scenario: DEPTH=32, all req held with deq_req=0 -> exactly 32 q_en pulses, then full=1 and q_en stays 0; one deq_gnt -> count=31 and one further q_en follows.
REQ-034 Verification SHALL cover the following scenario: count=0 with deq_req=1 held while req[1] is raised -> deq_gnt=0 in the q_en cycle; in the next cycle deq_gnt=1 and count returns to 0.
REQ-035 Verification SHALL cover the following scenario: count=5 with q_en=1 and deq_gnt=1 in the same cycle -> count stays 5.
REQ-036 Verification SHALL cover the following scenario: rst_n pulsed low in the cycle after a grant -> q_en, ack, and count are 0 immediately, and the first grant after reset release goes to core 0.

Source files
------------

// File: rtl/rt_ic_pkg.sv
// Shared RT/IC interconnect constants: producer count, queue depth and payload widths.
package rt_ic_pkg;

  localparam int NUM_CORE = 4;
  localparam int DEPTH    = 32;
  localparam int RT2IC_W  = 64;
  localparam int IC2RT_W  = 32;

  // Occupancy must represent every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEPTH);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: nearest requester strictly after i_ptr wins, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    o_gnt = '0;
    // Scan from farthest to nearest offset; the last hit (nearest) overwrites earlier ones.
    for (int off = N; off >= 1; off--) begin
      for (int i = 0; i < N; i++) begin
        if (i_req[i] && (((int'(i_ptr) + off) % N) == i)) begin
          o_gnt    = '0;
          o_gnt[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ic_enq_arbiter.sv
// Arbitrates NUM_CORE producers onto one queue, registering the enqueue strobe and tracking occupancy.
module ic_enq_arbiter #(
  parameter int  NUM_CORE = rt_ic_pkg::NUM_CORE,
  parameter int  DEPTH    = rt_ic_pkg::DEPTH,
  localparam int CNT_W    = rt_ic_pkg::cnt_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CORE-1:0] req,
  input  logic                deq_req,
  output logic                q_en,
  output logic [NUM_CORE-1:0] core_id,
  output logic [NUM_CORE-1:0] ack,
  output logic                deq_gnt,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty
);

  localparam int             PTR_W   = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

  logic                r_q_en;
  logic [NUM_CORE-1:0] r_core_id;
  logic [PTR_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_count;

  logic [NUM_CORE-1:0] w_elig;
  logic [NUM_CORE-1:0] w_arb_gnt;
  logic [NUM_CORE-1:0] w_gnt;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic                w_room;
  logic                w_grant_any;

  // A core already being acked this cycle must not win again on the same request.
  assign w_elig = req & ~ack;
  // The in-flight enqueue already holds a slot even though count has not caught up yet.
  assign w_room      = ({1'b0, r_count} + {{CNT_W{1'b0}}, r_q_en}) < DEPTH_V;
  assign w_gnt       = w_room ? w_arb_gnt : '0;
  assign w_grant_any = |w_gnt;

  rr_arbiter #(
    .N     (NUM_CORE),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      if (w_gnt[i]) w_gnt_idx = PTR_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the async reset also discards any grant decided in the cycle reset lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_en    <= 1'b0;
      r_core_id <= '0;
      r_ptr     <= PTR_W'(NUM_CORE - 1);
      r_count   <= '0;
    end else begin
      r_q_en    <= w_grant_any;
      r_core_id <= w_gnt;
      if (w_grant_any) r_ptr <= w_gnt_idx;
      if (r_q_en && !deq_gnt)      r_count <= r_count + CNT_W'(1);
      else if (deq_gnt && !r_q_en) r_count <= r_count - CNT_W'(1);
    end
  end

  assign q_en    = r_q_en;
  assign core_id = r_core_id;
  assign ack     = r_core_id & {NUM_CORE{r_q_en}};
  assign count   = r_count;
  assign empty   = (r_count == '0);
  assign full    = (r_count == CNT_W'(DEPTH));
  // An entry enqueued this cycle is not written yet, so it cannot be dequeued until next cycle.
  assign deq_gnt = deq_req & ~empty;

endmodule

// File: tb/tb_ic_enq_arbiter.sv
// Self-checking bench: hand-derived vector table, directed corner sequences, random scoreboard run.
module tb_ic_enq_arbiter;

  localparam int N  = 4;
  localparam int D  = 32;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          deq_req = 1'b0;
  logic          q_en;
  logic [N-1:0]  core_id;
  logic [N-1:0]  ack;
  logic          deq_gnt;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  ic_enq_arbiter #(.NUM_CORE(N), .DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .deq_req (deq_req),
    .q_en    (q_en),
    .core_id (core_id),
    .ack     (ack),
    .deq_gnt (deq_gnt),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         deq;
    logic         qen;
    logic [N-1:0] core;
    int           cnt;
    logic         dg;
  } vec_t;

  typedef struct {
    logic         qen;
    logic [N-1:0] core;
    int           cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic [N-1:0] r, input logic dq, input logic qe,
                              input logic [N-1:0] c, input int cn, input logic g);
    vec_t v;
    v.req = r; v.deq = dq; v.qen = qe; v.core = c; v.cnt = cn; v.dg = g;
    return v;
  endfunction

  initial begin
    int           pulses;
    int           m_ptr;
    logic [N-1:0] last_ack;
    exp_t         e;
    exp_t         nx;
    logic [N-1:0] elig;
    logic [1:0]   c;
    logic         dg;
    int           widx;

    // Rotation from reset, then same-cycle enq/deq at count 5, drain, deq-while-empty, single requester.
    vecs.push_back(mk(4'b1111, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b1111, 0, 1, 4'b0001, 0, 0));
    vecs.push_back(mk(4'b1111, 0, 1, 4'b0010, 1, 0));
    vecs.push_back(mk(4'b1111, 0, 1, 4'b0100, 2, 0));
    vecs.push_back(mk(4'b1111, 0, 1, 4'b1000, 3, 0));
    vecs.push_back(mk(4'b1111, 0, 1, 4'b0001, 4, 0));
    vecs.push_back(mk(4'b0000, 1, 1, 4'b0010, 5, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 5, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 5, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 4, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 4, 1));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 3, 1));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 2, 1));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0010, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0010, 1, 1, 4'b0010, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0100, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0100, 0, 1, 4'b0100, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 4'b0000, 1, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst q_en", q_en, 0);
    check("rst core_id", core_id, 0);
    check("rst ack", ack, 0);
    check("rst count", count, 0);
    check("rst empty", empty, 1);
    check("rst full", full, 0);
    check("rst deq_gnt", deq_gnt, 0);
    next_cycle();
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      req     = vecs[k].req;
      deq_req = vecs[k].deq;
      @(negedge clk);
      check($sformatf("vec%0d q_en", k), q_en, vecs[k].qen);
      check($sformatf("vec%0d core_id", k), core_id, vecs[k].core);
      check($sformatf("vec%0d ack", k), ack, vecs[k].qen ? vecs[k].core : 4'b0000);
      check($sformatf("vec%0d count", k), count, vecs[k].cnt);
      check($sformatf("vec%0d deq_gnt", k), deq_gnt, vecs[k].dg);
      check($sformatf("vec%0d empty", k), empty, vecs[k].cnt == 0);
      check($sformatf("vec%0d full", k), full, vecs[k].cnt == D);
      next_cycle();
    end

    // Reset lands in the q_en cycle of a grant while another grant is pending.
    req = 4'b1111;
    next_cycle();
    check("prerst q_en", q_en, 1);
    check("prerst core_id", core_id, 4'b1000);
    rst_n = 1'b0;
    #1;
    check("midrst q_en", q_en, 0);
    check("midrst ack", ack, 0);
    check("midrst core_id", core_id, 0);
    check("midrst count", count, 0);
    check("midrst empty", empty, 1);
    check("midrst full", full, 0);
    next_cycle();
    rst_n = 1'b1;

    // Fill to DEPTH with every core requesting and no dequeues.
    pulses = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("postrst no stale q_en", q_en, 0);
      if (q_en) begin
        if (pulses == 0) check("postrst first core", core_id, 4'b0001);
        pulses++;
      end
      next_cycle();
    end
    check("fill pulses", pulses, D);
    @(negedge clk);
    check("fill full", full, 1);
    check("fill count", count, D);
    check("fill q_en idle", q_en, 0);
    deq_req = 1'b1;
    #1;
    check("full deq_gnt", deq_gnt, 1);
    next_cycle();
    deq_req = 1'b0;
    @(negedge clk);
    check("after deq count", count, D - 1);
    check("after deq full", full, 0);
    pulses = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      next_cycle();
      @(negedge clk);
      if (q_en) pulses++;
    end
    check("refill pulses", pulses, 1);
    check("refill count", count, D);

    // Random protocol-compliant traffic against a behavioural scoreboard.
    next_cycle();
    req = '0;
    deq_req = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    m_ptr = N - 1;
    last_ack = '0;
    e.qen = 1'b0; e.core = '0; e.cnt = 0;
    sb.push_back(e);
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (last_ack[i]) req[i] = ($urandom_range(0, 1) == 1);
        end else begin
          req[i] = ($urandom_range(0, 2) == 0);
        end
      end
      deq_req = ($urandom_range(0, 4) < 2);
      @(negedge clk);
      if (sb.size() == 0) begin
        check("sb underflow", 1, 0);
        break;
      end
      e = sb.pop_front();
      dg = deq_req && (e.cnt != 0);
      check($sformatf("rnd%0d q_en", cyc), q_en, e.qen);
      check($sformatf("rnd%0d core_id", cyc), core_id, e.core);
      check($sformatf("rnd%0d ack", cyc), ack, e.qen ? e.core : 4'b0000);
      check($sformatf("rnd%0d count", cyc), count, e.cnt);
      check($sformatf("rnd%0d deq_gnt", cyc), deq_gnt, dg);
      last_ack = e.qen ? e.core : '0;
      elig = req & ~last_ack;
      widx = -1;
      if (e.cnt + int'(e.qen) < D) begin
        for (int j = 1; j <= N; j++) begin
          c = 2'((m_ptr + j) % N);
          if (widx < 0 && elig[c]) widx = int'(c);
        end
      end
      nx.qen  = (widx >= 0);
      nx.core = (widx >= 0) ? (4'b0001 << widx) : 4'b0000;
      nx.cnt  = e.cnt + ((e.qen && !dg) ? 1 : 0) - ((dg && !e.qen) ? 1 : 0);
      if (widx >= 0) m_ptr = widx;
      sb.push_back(nx);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
